noise_gen_stream: RTL and testbench



---
 rtl/noise_gen_stream.sv | 249 ++++++++++++++++++++++++
 tb/tb_noise_gen_stream.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_gen_stream.sv
// noise_gen_stream: CH independent 32-bit Galois LFSR noise channels with
// uniform / triangular / CLT-gaussian shaping, delivered on a valid/ready
// stream with run-time per-channel seed loading.
// Optional feature macro: NOISE_STATS_EN (adds stat_clr / sample_cnt).
module noise_gen_stream #(
    parameter int unsigned W       = 8,
    parameter int unsigned CH      = 4,
    parameter int unsigned SUM_N   = 4,
    parameter logic [31:0] TAPMASK = 32'hA3000000,
    parameter logic [31:0] SEED    = 32'h1F2E3D4C
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            enable,
    input  logic [1:0]      mode,
    input  logic            seed_load,
    input  logic [2:0]      seed_ch,
    input  logic [31:0]     seed_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH*W-1:0] out_data,
    output logic            busy
`ifdef NOISE_STATS_EN
    ,
    input  logic            stat_clr,
    output logic [15:0]     sample_cnt
`endif
);

    localparam int unsigned AW    = W + 4;
    localparam int unsigned LOG_N = $clog2(SUM_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    // One Galois right-shift step of the LFSR.
    function automatic logic [31:0] lfsrStep(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? TAPMASK : 32'h0);
    endfunction

    // W unrolled steps: one fresh sample worth of state.
    function automatic logic [31:0] lfsrAdvance(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < int'(W); i++) begin
            t = lfsrStep(t);
        end
        return t;
    endfunction

    // Per-channel reset seed; golden-ratio multiples decorrelate channels.
    function automatic logic [31:0] resetSeed(input int c);
        return SEED ^ (32'h9E3779B9 * 32'(c + 1));
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [31:0]          lfsr_q [CH];
    logic [31:0]          lfsr_d [CH];
    logic signed [AW-1:0] acc_q [CH];
    logic signed [AW-1:0] acc_d [CH];
    logic [CH*W-1:0]      outData_q, outData_d;
    logic                 outValid_q, outValid_d;

    logic [31:0]          advanced  [CH];
    logic signed [AW-1:0] sampleExt [CH];
    logic signed [AW-1:0] accSum    [CH];
    logic [4:0]           kCur;
    logic [2:0]           shiftCur;
    logic                 handshake;
    logic                 accumStep;
    logic                 loadHit;
    logic                 restart;

    // Samples per output and the matching mean shift, from the latched mode.
    always_comb begin
        kCur     = 5'd1;
        shiftCur = 3'd0;
        case (mode_q)
            2'd1: begin
                kCur     = 5'd2;
                shiftCur = 3'd1;
            end
            2'd2: begin
                kCur     = 5'(SUM_N);
                shiftCur = 3'(LOG_N);
            end
            default: begin
                kCur     = 5'd1;
                shiftCur = 3'd0;
            end
        endcase
    end

    // Advanced LFSR state, sign-extended sample and running sum per channel.
    always_comb begin
        for (int c = 0; c < int'(CH); c++) begin
            advanced[c]  = lfsrAdvance(lfsr_q[c]);
            sampleExt[c] = {{4{advanced[c][31]}}, advanced[c][31:32-W]};
            accSum[c]    = acc_q[c] + sampleExt[c];
        end
    end

    assign handshake = (state_q == PRESENT) && out_ready;
    assign accumStep = ((state_q == ACCUM) && (cnt_q < kCur)) || (handshake && enable);
    assign loadHit   = seed_load && (32'(seed_ch) < CH);
    assign restart   = loadHit && ((state_q == ACCUM) || (handshake && enable));

    // Next-state logic: IDLE -> ACCUM (K sums, then register mean) -> PRESENT.
    // A handshake that continues straight into ACCUM takes the first sample
    // in the same cycle, so back-to-back output sets come every K+1 cycles.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        lfsr_d     = lfsr_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    mode_d = mode;
                    cnt_d  = 5'd0;
                    for (int c = 0; c < int'(CH); c++) begin
                        acc_d[c] = '0;
                    end
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (cnt_q < kCur) begin
                    for (int c = 0; c < int'(CH); c++) begin
                        acc_d[c] = accSum[c];
                    end
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    for (int c = 0; c < int'(CH); c++) begin
                        outData_d[c*W +: W] = W'(acc_q[c] >>> shiftCur);
                    end
                    outValid_d = 1'b1;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    if (enable) begin
                        mode_d = mode;
                        for (int c = 0; c < int'(CH); c++) begin
                            acc_d[c] = sampleExt[c];
                        end
                        cnt_d   = 5'd1;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accumStep) begin
            for (int c = 0; c < int'(CH); c++) begin
                lfsr_d[c] = advanced[c];
            end
        end

        if (loadHit) begin
            for (int c = 0; c < int'(CH); c++) begin
                if (seed_ch == 3'(c)) begin
                    lfsr_d[c] = (seed_data == 32'h0) ? resetSeed(c) : seed_data;
                end
            end
        end

        if (restart) begin
            for (int c = 0; c < int'(CH); c++) begin
                acc_d[c] = '0;
            end
            cnt_d      = 5'd0;
            state_d    = ACCUM;
            outData_d  = outData_q;
            outValid_d = 1'b0;
        end
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            mode_q     <= 2'd0;
            cnt_q      <= 5'd0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            for (int c = 0; c < int'(CH); c++) begin
                lfsr_q[c] <= resetSeed(c);
                acc_q[c]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            for (int c = 0; c < int'(CH); c++) begin
                lfsr_q[c] <= lfsr_d[c];
                acc_q[c]  <= acc_d[c];
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign busy      = (state_q != IDLE);

`ifdef NOISE_STATS_EN
    logic [15:0] sampleCnt_q, sampleCnt_d;

    // Saturating handshake counter; clear beats increment.
    always_comb begin
        sampleCnt_d = sampleCnt_q;
        if (stat_clr) begin
            sampleCnt_d = 16'h0;
        end else if (handshake && (sampleCnt_q != 16'hFFFF)) begin
            sampleCnt_d = sampleCnt_q + 16'h1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sampleCnt_q <= 16'h0;
        end else begin
            sampleCnt_q <= sampleCnt_d;
        end
    end

    assign sample_cnt = sampleCnt_q;
`endif

endmodule

// File: tb/tb_noise_gen_stream.sv
// Directed self-checking bench for noise_gen_stream (W=8, CH=4, SUM_N=4).
module tb_noise_gen_stream;

    localparam logic [31:0] SEED    = 32'h1F2E3D4C;
    localparam logic [31:0] TAPMASK = 32'hA3000000;

    logic        clk;
    logic        n_reset;
    logic        enable;
    logic [1:0]  mode;
    logic        seed_load;
    logic [2:0]  seed_ch;
    logic [31:0] seed_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
`ifdef NOISE_STATS_EN
    logic        stat_clr;
    logic [15:0] sample_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] mLfsr [4];
    logic [31:0] expSet;
    logic [31:0] held;

    noise_gen_stream #(
        .W(8), .CH(4), .SUM_N(4), .TAPMASK(TAPMASK), .SEED(SEED)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .enable(enable),
        .mode(mode),
        .seed_load(seed_load),
        .seed_ch(seed_ch),
        .seed_data(seed_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy)
`ifdef NOISE_STATS_EN
        ,
        .stat_clr(stat_clr),
        .sample_cnt(sample_cnt)
`endif
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mStep(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ TAPMASK;
        return n;
    endfunction

    function automatic logic [31:0] mAdv(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 8; i++) t = mStep(t);
        return t;
    endfunction

    function automatic logic [31:0] mSeed(input int c);
        return SEED ^ (32'h9E3779B9 * 32'(c + 1));
    endfunction

    task automatic resetModel();
        for (int c = 0; c < 4; c++) mLfsr[c] = mSeed(c);
    endtask

    // Mean of k fresh samples per channel, floor division by 2^sh.
    task automatic modelSample(input int k, input int sh, output logic [31:0] res);
        int sum;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            sum = 0;
            for (int j = 0; j < k; j++) begin
                mLfsr[c] = mAdv(mLfsr[c]);
                sum += int'($signed(mLfsr[c][31:24]));
            end
            res[c*8 +: 8] = 8'(sum >>> sh);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] md, input logic rdy);
        enable    = en;
        mode      = md;
        out_ready = rdy;
    endtask

    // Counts edges until out_valid is seen, bounded.
    task automatic waitValid(input string tag, input int expN);
        int n;
        n = 0;
        do begin
            waitEdge();
            n++;
        end while (out_valid !== 1'b1 && n < 40);
        checkOutput(tag, 32'(n), 32'(expN));
    endtask

    // Directed sequence.
    initial begin
        n_reset   = 1'b0;
        enable    = 1'b0;
        mode      = 2'd0;
        out_ready = 1'b1;
        seed_load = 1'b0;
        seed_ch   = 3'd0;
        seed_data = 32'h0;
`ifdef NOISE_STATS_EN
        stat_clr  = 1'b0;
`endif
        resetModel();
        #3;
        checkOutput("rst.valid", 32'(out_valid), 32'd0);
        checkOutput("rst.data", out_data, 32'h0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        waitEdge();
        waitEdge();
        n_reset = 1'b1;
        waitEdge();
        checkOutput("idle.busy", 32'(busy), 32'd0);

        // Seed 1 on channel 0, uniform: hand values 8'h01 then 8'h00.
        seed_load = 1'b1; seed_ch = 3'd0; seed_data = 32'h1;
        waitEdge();
        seed_load = 1'b0;
        mLfsr[0] = 32'h1;
        applyStimulus(1'b1, 2'd0, 1'b1);
        waitEdge();
        checkOutput("A.busy", 32'(busy), 32'd1);
        waitValid("A.lat1", 2);
        checkOutput("A.first", {24'h0, out_data[7:0]}, 32'h01);
        modelSample(1, 0, expSet);
        checkOutput("A.set1", out_data, expSet);
        waitValid("A.lat2", 2);
        checkOutput("A.second", {24'h0, out_data[7:0]}, 32'h00);
        modelSample(1, 0, expSet);
        checkOutput("A.set2", out_data, expSet);
        applyStimulus(1'b0, 2'd0, 1'b1);
        waitEdge();
        checkOutput("A.idle", {30'h0, busy, out_valid}, 32'h0);

        // Gaussian: K+1 edges after IDLE exit, then one set every 5 cycles.
        applyStimulus(1'b1, 2'd2, 1'b1);
        waitValid("B.lat", 6);
        modelSample(4, 2, expSet);
        checkOutput("B.set0", out_data, expSet);
        for (int i = 0; i < 3; i++) begin
            waitValid("B.period", 5);
            modelSample(4, 2, expSet);
            checkOutput("B.set", out_data, expSet);
        end
        applyStimulus(1'b0, 2'd2, 1'b1);
        waitEdge();

        // Triangular, then mode 3 behaving as uniform.
        applyStimulus(1'b1, 2'd1, 1'b1);
        waitValid("C.triLat", 4);
        modelSample(2, 1, expSet);
        checkOutput("C.tri", out_data, expSet);
        applyStimulus(1'b0, 2'd1, 1'b1);
        waitEdge();
        applyStimulus(1'b1, 2'd3, 1'b1);
        waitValid("C.m3Lat", 3);
        modelSample(1, 0, expSet);
        checkOutput("C.m3", out_data, expSet);
        applyStimulus(1'b0, 2'd3, 1'b1);
        waitEdge();

        // Back-pressure: 20 stalled cycles, then the sequence continues.
        applyStimulus(1'b1, 2'd0, 1'b0);
        waitValid("D.lat", 3);
        modelSample(1, 0, expSet);
        checkOutput("D.set", out_data, expSet);
        held = expSet;
        for (int i = 0; i < 20; i++) begin
            waitEdge();
            checkOutput("D.hold", out_data, held);
        end
        checkOutput("D.validHeld", 32'(out_valid), 32'd1);
        applyStimulus(1'b1, 2'd0, 1'b1);
        waitValid("D.relLat", 2);
        modelSample(1, 0, expSet);
        checkOutput("D.next", out_data, expSet);
        applyStimulus(1'b0, 2'd0, 1'b1);
        waitEdge();

        // Zero seed on channel 2 during ACCUM: reset seed, restart, 3-cycle delay.
        applyStimulus(1'b1, 2'd2, 1'b1);
        waitEdge();
        waitEdge();
        waitEdge();
        seed_load = 1'b1; seed_ch = 3'd2; seed_data = 32'h0;
        waitEdge();
        seed_load = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) mLfsr[c] = mSeed(2);
            else mLfsr[c] = mAdv(mAdv(mAdv(mLfsr[c])));
        end
        waitValid("E.lat", 5);
        modelSample(4, 2, expSet);
        checkOutput("E.set", out_data, expSet);
        applyStimulus(1'b0, 2'd2, 1'b1);
        waitEdge();

        // Out-of-range channel load and a mode change mid-ACCUM: both ignored.
        applyStimulus(1'b1, 2'd2, 1'b1);
        waitEdge();
        mode = 2'd0;
        waitEdge();
        seed_load = 1'b1; seed_ch = 3'd7; seed_data = 32'hDEADBEEF;
        waitEdge();
        seed_load = 1'b0;
        waitValid("F.lat", 3);
        modelSample(4, 2, expSet);
        checkOutput("F.set", out_data, expSet);
        applyStimulus(1'b0, 2'd0, 1'b1);
        waitEdge();

        // Asynchronous reset in PRESENT clears without a clock edge.
        applyStimulus(1'b1, 2'd0, 1'b0);
        waitValid("G.lat", 3);
        #3;
        n_reset = 1'b0;
        #1;
        checkOutput("G.asyncValid", 32'(out_valid), 32'd0);
        checkOutput("G.asyncBusy", 32'(busy), 32'd0);
        checkOutput("G.asyncData", out_data, 32'h0);
        applyStimulus(1'b0, 2'd0, 1'b1);
        waitEdge();
        n_reset = 1'b1;
        waitEdge();
        resetModel();
        applyStimulus(1'b1, 2'd0, 1'b1);
        waitValid("G.postLat", 3);
        modelSample(1, 0, expSet);
        checkOutput("G.postSet", out_data, expSet);
        applyStimulus(1'b0, 2'd0, 1'b1);
        waitEdge();

`ifdef NOISE_STATS_EN
        // Handshake counter: count, clear-wins, saturation.
        checkOutput("H.start", 32'(sample_cnt), 32'd1);
        stat_clr = 1'b1;
        waitEdge();
        stat_clr = 1'b0;
        checkOutput("H.clr", 32'(sample_cnt), 32'd0);
        applyStimulus(1'b1, 2'd0, 1'b1);
        waitValid("H.l1", 3);
        waitValid("H.l2", 2);
        waitValid("H.l3", 2);
        applyStimulus(1'b0, 2'd0, 1'b1);
        waitEdge();
        checkOutput("H.three", 32'(sample_cnt), 32'd3);
        applyStimulus(1'b1, 2'd0, 1'b1);
        waitValid("H.l4", 3);
        stat_clr = 1'b1;
        enable   = 1'b0;
        waitEdge();
        stat_clr = 1'b0;
        checkOutput("H.clrWins", 32'(sample_cnt), 32'd0);
        applyStimulus(1'b1, 2'd0, 1'b1);
        waitValid("H.l5", 3);
        force dut.sampleCnt_q = 16'hFFFF;
        #1;
        release dut.sampleCnt_q;
        enable = 1'b0;
        waitEdge();
        checkOutput("H.sat", 32'(sample_cnt), 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
